demux_route_ctrl: RTL
=====================

DEMUX_ROUTE_CTRL -- requirements
Module: demux_route_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of the routed word.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port mode  input  1  routing mode: 0 = steered by in_dst, 1 = alternating ping-pong.
REQ-005 The block SHALL have port in_valid  input  1  input word present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept the input word this cycle.
REQ-007 The block SHALL have port in_data  input  WIDTH  input word.
REQ-008 The block SHALL have port in_dst  input  1  destination in mode 0: 0 = channel 0, 1 = channel 1.
REQ-009 The block SHALL have ports out0_valid/out1_valid  output  1 each  channel word present.
REQ-010 The block SHALL have ports out0_ready/out1_ready  input  1 each  channel consumer accepts.
REQ-011 The block SHALL have ports out0_data/out1_data  output  WIDTH each  channel head word.
REQ-012 The block SHALL have ports cnt0/cnt1  output  8 each  words delivered per channel.
REQ-013 The block SHALL have port cnt_clr  input  1  synchronous clear of cnt0 and cnt1.

Function
REQ-014 Each channel SHALL own a 2-entry FIFO; word order within a channel SHALL be preserved.
REQ-015 Selected destination sel SHALL be in_dst when mode=0 and the ping-pong pointer rr when mode=1.
REQ-016 in_ready SHALL equal NOT full(FIFO[sel]), combinational from sel and FIFO state, independent of in_valid.
REQ-017 Full FIFO SHALL hold in_ready low even if that channel pops the same cycle (no pass-through).
REQ-018 Accept (in_valid AND in_ready) SHALL write in_data into FIFO[sel] at that clock edge; no write otherwise.
REQ-019 rr SHALL toggle only on an accept while mode=1; it SHALL hold in mode=0 and on stalls.
REQ-020 Mode changes SHALL take effect the same cycle; words already queued SHALL stay in their channel.
REQ-021 outN_valid SHALL be 1 exactly when FIFO N is non-empty; outN_data SHALL be the FIFO N head.
REQ-022 Latency SHALL be one cycle: word accepted at edge k appears on outN_data with outN_valid=1 after edge k when FIFO N was empty.
REQ-023 Pop SHALL occur on outN_valid AND outN_ready; outN_ready while empty SHALL have no effect.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and order intact.
REQ-025 outN_data SHALL hold its value while outN_valid=1 and outN_ready=0.
REQ-026 cntN SHALL increment by 1 on each pop of channel N and wrap 255 -> 0.
REQ-027 cnt_clr SHALL set both counters to 0 and SHALL take priority over a same-cycle pop.
REQ-028 Channels SHALL operate independently; backpressure on one SHALL not stall accepts to the other.

Reset
REQ-029 With rst=1 at a clock edge, both FIFOs SHALL become empty, rr=0, cnt0=cnt1=0, out0_valid=out1_valid=0, out0_data=out1_data=0.
REQ-030 Reset SHALL override any same-cycle accept, pop or cnt_clr; in-flight words SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-032 Mode 0, in_dst=0, in_data=0xA5, out0_ready=1 -> out0_valid=1, out0_data=0xA5 next cycle; out1_valid stays 0; cnt0=1.
REQ-033 Mode 1, words 0x01,0x02,0x03,0x04 back-to-back, both ready=1 -> ch0 gets 0x01,0x03, ch1 gets 0x02,0x04; cnt0=cnt1=2.
REQ-034 Mode 0, in_dst=1, out1_ready=0, three words -> first two queued, in_ready=0 on third; raising out1_ready with third still offered -> in_ready stays 0 that cycle, third accepted next cycle, delivery order preserved.
REQ-035 Channel 1 full and stalled, in_dst=0 words -> accepted and delivered on channel 0 without stall.
REQ-036 256 pops on channel 0 -> cnt0 wraps to 0; cnt_clr asserted together with a pop -> cnt0=0.
REQ-037 rst asserted with both FIFOs holding data -> next cycle all valids 0, data 0, counters 0, in_ready=1, rr=0.

Source files
------------

// File: rtl/demux_route_ctrl.sv
// Routes one input stream into two channels, each buffered by a 2-entry FIFO,
// either steered by in_dst or alternating ping-pong; counts words delivered per channel.
`timescale 1ns/1ps

module demux_route_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dst,
    output logic             out0_valid,
    output logic             out1_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    input  logic             cnt_clr
);

    logic [1:0][1:0][WIDTH-1:0] mem;
    logic [1:0]                 wp;
    logic [1:0]                 rp;
    logic [1:0][1:0]            count;
    logic                       rr;
    logic                       sel;
    logic                       accept;
    logic [1:0]                 full;
    logic [1:0]                 push;
    logic [1:0]                 pop;
    logic [1:0]                 chan_ready;
    logic [1:0][7:0]            cnt;

    assign chan_ready = {out1_ready, out0_ready};

    // A full FIFO never accepts, even if it drains this same cycle.
    always_comb begin
        sel      = mode ? rr : in_dst;
        full     = '0;
        push     = '0;
        pop      = '0;
        for (int n = 0; n < 2; n++) begin
            full[n] = (count[n] == 2'd2);
            pop[n]  = (count[n] != 2'd0) && chan_ready[n];
        end
        in_ready = !full[sel];
        accept   = in_valid && in_ready;
        push[sel] = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            rr    <= 1'b0;
            cnt   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    mem[n][wp[n]] <= in_data;
                    wp[n]         <= ~wp[n];
                end
                if (pop[n]) begin
                    rp[n] <= ~rp[n];
                end
                count[n] <= count[n] + 2'(push[n]) - 2'(pop[n]);
                // Clear wins over a same-cycle delivery.
                if (cnt_clr) begin
                    cnt[n] <= 8'd0;
                end else if (pop[n]) begin
                    cnt[n] <= cnt[n] + 8'd1;
                end
            end
            if (accept && mode) begin
                rr <= ~rr;
            end
        end
    end

    assign out0_valid = (count[0] != 2'd0);
    assign out1_valid = (count[1] != 2'd0);
    assign out0_data  = mem[0][rp[0]];
    assign out1_data  = mem[1][rp[1]];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];

endmodule
